// File: rtl/bfp_pkg.sv
// ---------------------------------------------------------------------------
// bfp_pkg
// Shared definitions for the FP32 -> block-floating-point packer:
//   - default group geometry (GRPSIZE / BFPEXPSIZE / BFPMANSIZE)
//   - IEEE-754 single field widths and the fp32_t view of a raw word
//   - the packer FSM state type
// ---------------------------------------------------------------------------
package bfp_pkg;

   localparam int GRPSIZE_DEF    = 16;
   localparam int BFPEXPSIZE_DEF = 8;
   localparam int BFPMANSIZE_DEF = 4;

   localparam int FP32_W      = 32;
   localparam int FP32_EXP_W  = 8;
   localparam int FP32_FRAC_W = 23;

   typedef struct packed {
      logic                   sign;
      logic [FP32_EXP_W-1:0]  exp;
      logic [FP32_FRAC_W-1:0] frac;
   } fp32_t;

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_t;

   // Exponent field of zero marks zero/denormal: such elements carry no weight.
   function automatic logic exp_is_zero(input fp32_t fp);
      return (fp.exp == {FP32_EXP_W{1'b0}});
   endfunction

endpackage

// File: rtl/fp2bfp_align.sv
// ---------------------------------------------------------------------------
// fp2bfp_align
// Combinational conversion of one FP32 element into a BFP mantissa
// {sign, magnitude} relative to the group's shared exponent.
//   i_fp      : FP32 element
//   i_maxexp  : shared (maximum) biased exponent of the group
//   o_man     : {sign, 0.mmm} magnitude, sign forced 0 when magnitude is 0
// Build option: FP2BFP_RNE_EN selects round-to-nearest-even on the
// discarded bits (saturating); otherwise the magnitude is truncated.
// ---------------------------------------------------------------------------
module fp2bfp_align
   import bfp_pkg::*;
#(
   parameter int BFPEXPSIZE = BFPEXPSIZE_DEF,
   parameter int BFPMANSIZE = BFPMANSIZE_DEF
) (
   input  fp32_t                 i_fp,
   input  logic [BFPEXPSIZE-1:0] i_maxexp,
   output logic [BFPMANSIZE-1:0] o_man
);

   localparam int MW   = BFPMANSIZE - 1;          // magnitude bits
   localparam int EXTW = 2 * (FP32_FRAC_W + 1);   // significand plus room for shifted-out bits

`ifdef FP2BFP_RNE_EN
   localparam bit RNE_EN = 1'b1;
`else
   localparam bit RNE_EN = 1'b0;
`endif

   logic [BFPEXPSIZE-1:0] dist_s;
   logic [EXTW-1:0]       ext_s;
   logic [MW-1:0]         mag_s;
   logic [MW:0]           mag_rnd_s;
   logic [MW-1:0]         mag_fin_s;
   logic                  guard_s;
   logic                  sticky_s;
   logic                  round_up_s;

   // Shift the 0.1fff significand down by the exponent distance, then round or truncate.
   always_comb begin
      dist_s     = i_maxexp - BFPEXPSIZE'(i_fp.exp);
      ext_s      = {1'b1, i_fp.frac, {(FP32_FRAC_W + 1){1'b0}}} >> dist_s;
      mag_s      = ext_s[EXTW-1 -: MW];
      guard_s    = ext_s[EXTW-1-MW];
      sticky_s   = |ext_s[EXTW-2-MW:0];
      round_up_s = RNE_EN & guard_s & (sticky_s | mag_s[0]);
      mag_rnd_s  = {1'b0, mag_s} + {{MW{1'b0}}, round_up_s};
      if (exp_is_zero(i_fp)) begin
         mag_fin_s = {MW{1'b0}};
      end else if (mag_rnd_s[MW]) begin
         mag_fin_s = {MW{1'b1}};             // rounding overflow saturates
      end else begin
         mag_fin_s = mag_rnd_s[MW-1:0];
      end
      o_man = {i_fp.sign & (|mag_fin_s), mag_fin_s};
   end

endmodule

// File: rtl/fp2bfp_pack.sv
// ---------------------------------------------------------------------------
// fp2bfp_pack
// Collects up to GRPSIZE FP32 elements, then emits them as one BFP group:
// a shared exponent (max biased exponent of non-zero elements) and one
// {sign, 0.mmm} mantissa per element, slot 0 being the first accepted.
//   i_clk, i_reset_n      : clock, async active-low reset
//   i_valid/o_ready, i_fp : element input handshake and data
//   i_flush               : close a partial (non-empty) group early
//   o_valid/i_ready       : group output handshake
//   o_E, o_M              : shared exponent, per-element mantissas
// Build option: FP2BFP_RNE_EN (round-to-nearest-even instead of truncation).
// ---------------------------------------------------------------------------
module fp2bfp_pack
   import bfp_pkg::*;
#(
   parameter int GRPSIZE    = GRPSIZE_DEF,
   parameter int BFPEXPSIZE = BFPEXPSIZE_DEF,
   parameter int BFPMANSIZE = BFPMANSIZE_DEF
) (
   input  logic                                i_clk,
   input  logic                                i_reset_n,
   input  logic                                i_valid,
   output logic                                o_ready,
   input  logic [FP32_W-1:0]                   i_fp,
   input  logic                                i_flush,
   output logic                                o_valid,
   input  logic                                i_ready,
   output logic [BFPEXPSIZE-1:0]               o_E,
   output logic [GRPSIZE-1:0][BFPMANSIZE-1:0]  o_M
);

   localparam int CNTW = $clog2(GRPSIZE);

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [CNTW-1:0]        cnt_r;
   logic [BFPEXPSIZE-1:0]  max_r;
   logic [BFPEXPSIZE-1:0]  max_nxt_s;
   fp32_t                  store_r     [GRPSIZE];
   fp32_t                  store_nxt_s [GRPSIZE];
   logic [BFPMANSIZE-1:0]  man_s       [GRPSIZE];
   fp32_t                  fp_in_s;
   logic                   accept_s;
   logic                   close_s;
   logic                   handshake_s;

   assign fp_in_s = fp32_t'(i_fp);
   assign o_ready = (state_r == COLLECT);

   // Accept/close/handshake decode and the post-accept view of storage and max.
   // Alignment runs on that view so the group is complete in the same edge that closes it.
   always_comb begin
      accept_s    = (state_r == COLLECT) & i_valid;
      handshake_s = (state_r == EMIT) & i_ready;
      close_s     = (accept_s & (cnt_r == CNTW'(GRPSIZE - 1)))
                  | ((state_r == COLLECT) & i_flush & ((cnt_r != {CNTW{1'b0}}) | accept_s));
      if (accept_s && !exp_is_zero(fp_in_s) && (BFPEXPSIZE'(fp_in_s.exp) > max_r)) begin
         max_nxt_s = BFPEXPSIZE'(fp_in_s.exp);
      end else begin
         max_nxt_s = max_r;
      end
      for (int i = 0; i < GRPSIZE; i++) begin
         if (accept_s && (cnt_r == CNTW'(i))) begin
            store_nxt_s[i] = fp_in_s;
         end else begin
            store_nxt_s[i] = store_r[i];
         end
      end
   end

   // Per-element alignment against the group's shared exponent.
   for (genvar g = 0; g < GRPSIZE; g++) begin : g_align
      fp2bfp_align #(
         .BFPEXPSIZE (BFPEXPSIZE),
         .BFPMANSIZE (BFPMANSIZE)
      ) u_align (
         .i_fp     (store_nxt_s[g]),
         .i_maxexp (max_nxt_s),
         .o_man    (man_s[g])
      );
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r <= COLLECT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         COLLECT: begin
            if (close_s) begin
               state_nxt_s = EMIT;
            end else begin
               state_nxt_s = COLLECT;
            end
         end
         EMIT: begin
            if (i_ready) begin
               state_nxt_s = COLLECT;
            end else begin
               state_nxt_s = EMIT;
            end
         end
         default: state_nxt_s = COLLECT;
      endcase
   end

   // Element storage, slot counter and running max; all cleared once a group is taken.
   // Cleared slots read as exponent 0, which is what gives flushed groups zero padding.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_r <= {CNTW{1'b0}};
         max_r <= {BFPEXPSIZE{1'b0}};
         for (int i = 0; i < GRPSIZE; i++) begin
            store_r[i] <= '0;
         end
      end else if (handshake_s) begin
         cnt_r <= {CNTW{1'b0}};
         max_r <= {BFPEXPSIZE{1'b0}};
         for (int i = 0; i < GRPSIZE; i++) begin
            store_r[i] <= '0;
         end
      end else if (accept_s) begin
         cnt_r <= cnt_r + CNTW'(1);
         max_r <= max_nxt_s;
         for (int i = 0; i < GRPSIZE; i++) begin
            store_r[i] <= store_nxt_s[i];
         end
      end else begin
         cnt_r <= cnt_r;
         max_r <= max_r;
      end
   end

   // Group output registers: loaded on close, held through EMIT.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_valid <= 1'b0;
         o_E     <= {BFPEXPSIZE{1'b0}};
         o_M     <= '0;
      end else if (close_s) begin
         o_valid <= 1'b1;
         o_E     <= max_nxt_s;
         for (int i = 0; i < GRPSIZE; i++) begin
            o_M[i] <= man_s[i];
         end
      end else if (handshake_s) begin
         o_valid <= 1'b0;
      end else begin
         o_valid <= o_valid;
      end
   end

endmodule

// File: tb/tb_fp2bfp_pack.sv
// ---------------------------------------------------------------------------
// tb_fp2bfp_pack
// Self-checking bench for fp2bfp_pack. The reference model computes each
// mantissa as the element's value expressed in eighths of 2^(E-126),
// truncated (or rounded to nearest-even when FP2BFP_RNE_EN is defined).
// ---------------------------------------------------------------------------
module tb_fp2bfp_pack;

   localparam int G = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              valid;
   logic              ready_out;
   logic [31:0]       fp;
   logic              flush;
   logic              grp_valid;
   logic              grp_ready;
   logic [7:0]        o_E;
   logic [G-1:0][3:0] o_M;

   int n_checks = 0;
   int n_pass   = 0;
   int base_exp = 127;

   logic [31:0]       mq[$];
   logic [7:0]        exp_e;
   logic [G-1:0][3:0] exp_m;

   fp2bfp_pack dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_valid   (valid),
      .o_ready   (ready_out),
      .i_fp      (fp),
      .i_flush   (flush),
      .o_valid   (grp_valid),
      .i_ready   (grp_ready),
      .o_E       (o_E),
      .o_M       (o_M)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: value = sig * 2^(e-150); in units of 2^(E-129) that is sig / 2^(21+E-e).
   function automatic void model();
      exp_e = 8'd0;
      foreach (mq[k]) begin
         if (mq[k][30:23] != 8'd0 && mq[k][30:23] > exp_e) exp_e = mq[k][30:23];
      end
      exp_m = '0;
      for (int k = 0; k < mq.size() && k < G; k++) begin
         longint unsigned sig, den, q, r;
         int e, sh;
         e = int'(mq[k][30:23]);
         if (e == 0) continue;
         sig = 64'd8388608 + 64'(mq[k][22:0]);
         sh  = 21 + int'(exp_e) - e;
         if (sh > 60) begin
            q = 0;
         end else begin
            den = 64'd1 << sh;
            q   = sig / den;
            r   = sig % den;
`ifdef FP2BFP_RNE_EN
            if ((2 * r > den) || ((2 * r == den) && (q % 2 == 1))) q = q + 1;
            if (q > 7) q = 7;
`else
            if (r > den) q = 0;
`endif
         end
         exp_m[k] = {mq[k][31] && (q != 0), 3'(q)};
      end
   endfunction

   function automatic logic [31:0] rnd_fp();
      int sel, e;
      sel = $urandom_range(0, 11);
      if (sel == 0)      e = 0;
      else if (sel == 1) e = 255;
      else begin
         e = base_exp - $urandom_range(0, 5);
         if (e < 1) e = 1;
      end
      return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
   endfunction

   task automatic push(input logic [31:0] v, input logic fl);
      @(negedge clk);
      valid = 1'b1;
      fp    = v;
      flush = fl;
      mq.push_back(v);
      @(posedge clk);
      #1;
      valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic flush_idle();
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   // Expects o_valid now (cycle after the close), compares, then takes the group.
   task automatic check_group(input string name, input int stall);
      model();
      n_checks++;
      if (grp_valid !== 1'b1) $display("FAIL %s latency: o_valid=%b required 1", name, grp_valid);
      else n_pass++;
      n_checks++;
      if (o_E !== exp_e) $display("FAIL %s exp: o_E=%0d required %0d", name, o_E, exp_e);
      else n_pass++;
      n_checks++;
      if (o_M !== exp_m) $display("FAIL %s man: o_M=%h required %h", name, o_M, exp_m);
      else n_pass++;
      n_checks++;
      if (ready_out !== 1'b0) $display("FAIL %s emit_ready: o_ready=%b required 0", name, ready_out);
      else n_pass++;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
      end
      grp_ready = 1'b1;
      @(posedge clk);
      #1;
      grp_ready = 1'b0;
      n_checks++;
      if (grp_valid !== 1'b0 || ready_out !== 1'b1)
         $display("FAIL %s drain: o_valid=%b o_ready=%b required 0/1", name, grp_valid, ready_out);
      else n_pass++;
      mq.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; valid = 1'b0; flush = 1'b0; grp_ready = 1'b0; fp = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (grp_valid !== 1'b0 || o_E !== 8'd0 || o_M !== '0)
         $display("FAIL reset_outputs: o_valid=%b o_E=%0d o_M=%h required 0/0/0", grp_valid, o_E, o_M);
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (ready_out !== 1'b1 || grp_valid !== 1'b0)
         $display("FAIL reset_ready: o_ready=%b o_valid=%b required 1/0", ready_out, grp_valid);
      else n_pass++;
   endtask

   task automatic test_full_ones();
      for (int i = 0; i < G - 1; i++) push(32'h3F800000, 1'b0);
      n_checks++;
      if (grp_valid !== 1'b0) $display("FAIL ones_early: o_valid=%b required 0", grp_valid);
      else n_pass++;
      push(32'h3F800000, 1'b0);
      n_checks++;
      if (o_E !== 8'd127 || o_M !== {G{4'b0100}})
         $display("FAIL ones_const: o_E=%0d o_M=%h required 127/%h", o_E, o_M, {G{4'b0100}});
      else n_pass++;
      check_group("ones", 0);
   endtask

   task automatic test_mixed();
      push(32'hC0400000, 1'b0);
      push(32'h3E800000, 1'b0);
      for (int i = 2; i < G; i++) push(32'h00000000, 1'b0);
      n_checks++;
      if (o_E !== 8'd128 || o_M[0] !== 4'b1110 || o_M[1] !== 4'b0000)
         $display("FAIL mixed_const: o_E=%0d m0=%b m1=%b required 128/1110/0000", o_E, o_M[0], o_M[1]);
      else n_pass++;
      check_group("mixed", 2);
   endtask

   task automatic test_flush();
      flush_idle();
      n_checks++;
      if (grp_valid !== 1'b0) $display("FAIL flush_empty: o_valid=%b required 0", grp_valid);
      else n_pass++;
      for (int i = 0; i < 5; i++) push(32'h3F800000, 1'b0);
      flush_idle();
      n_checks++;
      if (o_E !== 8'd127 || o_M !== {{(G-5){4'b0000}}, {5{4'b0100}}})
         $display("FAIL flush_const: o_E=%0d o_M=%h required 127 with five 0100", o_E, o_M);
      else n_pass++;
      check_group("flush_idle", 1);
      push(32'h40000000, 1'b0);
      push(32'hBF000000, 1'b1);
      check_group("flush_accept", 0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] x;
      for (int i = 0; i < G; i++) push(rnd_fp(), 1'b0);
      model();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         valid = 1'b1;
         fp    = $urandom;
         @(posedge clk);
         #1;
         n_checks++;
         if (grp_valid !== 1'b1 || ready_out !== 1'b0 || o_E !== exp_e || o_M !== exp_m)
            $display("FAIL stall_hold: cyc=%0d o_valid=%b o_ready=%b o_E=%0d required 1/0/%0d", c, grp_valid, ready_out, o_E, exp_e);
         else n_pass++;
      end
      x = rnd_fp();
      @(negedge clk);
      fp        = x;
      grp_ready = 1'b1;
      @(posedge clk);
      #1;
      grp_ready = 1'b0;
      mq.delete();
      mq.push_back(x);
      @(posedge clk);
      #1;
      valid = 1'b0;
      for (int i = 1; i < G; i++) push(rnd_fp(), 1'b0);
      check_group("after_stall", 0);
   endtask

   task automatic test_boundary();
      logic [31:0] pairs[7][2] = '{
         '{32'h3F800000, 32'h3FF80000},
         '{32'h3F800000, 32'h3FF00000},
         '{32'h3F800000, 32'h3FE80000},
         '{32'h40000000, 32'h3FF00000},
         '{32'h40000000, 32'h3FA00000},
         '{32'h7F800000, 32'h3F800000},
         '{32'h00000001, 32'h80000000}
      };
      for (int p = 0; p < 7; p++) begin
         push(pairs[p][0], 1'b0);
         push(pairs[p][1], 1'b1);
         check_group("boundary", 0);
      end
   endtask

   task automatic test_reset_midgroup();
      for (int i = 0; i < 7; i++) push(rnd_fp(), 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (grp_valid !== 1'b0 || ready_out !== 1'b1)
         $display("FAIL midreset: o_valid=%b o_ready=%b required 0/1", grp_valid, ready_out);
      else n_pass++;
      mq.delete();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (grp_valid !== 1'b0) $display("FAIL postreset: o_valid=%b required 0", grp_valid);
      else n_pass++;
      for (int i = 0; i < G; i++) push(rnd_fp(), 1'b0);
      check_group("clean_group", 0);
   endtask

   task automatic test_random();
      for (int g = 0; g < 30; g++) begin
         int len;
         base_exp = $urandom_range(1, 254);
         len = $urandom_range(1, G);
         for (int i = 0; i < len; i++) begin
            push(rnd_fp(), (i == len - 1) && (len < G) && ($urandom_range(0, 1) == 1));
         end
         if (len < G && grp_valid !== 1'b1) flush_idle();
         check_group("random", $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_full_ones();
      test_mixed();
      test_flush();
      test_back_to_back();
      test_boundary();
      test_reset_midgroup();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
